ahb_slave_mem: RTL



---
 rtl/ahb_slave_mem.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite subordinate in front of a word-organised scratch RAM.
//
// Behaviour:
//   Programmable OKAY wait states and little-endian byte/halfword/word writes.
//   The two-cycle ERROR response covers a bad size, a misaligned access or an
//   out-of-range address.
//
// Optional feature (macro AHB_SLV_RO_REGION_EN):
//   Words [0, RO_WORDS) become read-only. Writes to them take the ERROR path.
//
// Ports:
//   HCLK       bus clock, every register on its rising edge
//   HRESET     synchronous active-high reset
//   HSEL       slave select
//   HADDR      byte address
//   HTRANS     transfer type
//   HWRITE     1 = write, 0 = read
//   HSIZE      transfer size
//   HBURST     burst type (accepted, not decoded)
//   HWDATA     write data, sampled in the data phase
//   HREADY     bus-wide ready
//   HREADYOUT  this slave's ready
//   HRESP      0 = OKAY, 1 = ERROR
//   HRDATA     read data (full word, zero outside a read data phase)
//
// FSM states:
//   state  | meaning
//   S_IDLE | no data phase in progress
//   S_WAIT | OKAY data phase, inserting wait states
//   S_DATA | final OKAY data-phase cycle (write commits / read data valid)
//   S_ERR1 | first ERROR cycle, HREADYOUT low
//   S_ERR2 | second ERROR cycle, HREADYOUT high
module ahb_slave_mem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0,
  parameter int unsigned           RO_WORDS    = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [1:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH*4);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ERR     = 2'b11;
  localparam logic       RESP_OKAY    = 1'b0;
  localparam logic       RESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       size_q, size_d;
  logic             write_q, write_d;

  logic [31:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic accept;
  logic size_err, align_err, range_err, ro_err, xfer_err;
  logic [3:0] be;
  logic unused_ok;

  assign accept = HSEL & HREADY & ((HTRANS == TRANS_NONSEQ) | (HTRANS == TRANS_SEQ));

  // BASE_ADDR is aligned to the memory size, so the offset's low bits equal HADDR's.
  assign offset    = HADDR - BASE_ADDR;
  assign size_err  = (HSIZE == SIZE_ERR);
  assign align_err = ((HSIZE == SIZE_HALF) && offset[0]) ||
                     ((HSIZE == SIZE_WORD) && (offset[1:0] != 2'b00));
  assign range_err = ({1'b0, offset} >= MEM_BYTES);

`ifdef AHB_SLV_RO_REGION_EN
  assign ro_err    = HWRITE && ((offset >> 2) < ADDR_WIDTH'(RO_WORDS));
  assign unused_ok = ^HBURST;
`else
  localparam logic [31:0] RO_W = 32'(RO_WORDS);
  assign ro_err    = 1'b0;
  assign unused_ok = ^{HBURST, RO_W};
`endif

  assign xfer_err = size_err | align_err | range_err | ro_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // S_IDLE, S_DATA and S_ERR2 all end on this edge, so a new transfer
        // can be taken here back-to-back.
        if (accept) begin
          idx_d   = offset[IDX_W+1:2];
          lane_d  = offset[1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (xfer_err)              state_d = S_ERR1;
          else if (WAIT_STATES == 0) state_d = S_DATA;
          else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      SIZE_BYTE: be = 4'b0001 << lane_q;
      SIZE_HALF: be = lane_q[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end

  // No reset on the array; a reset on the closing edge drops the pending write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule
